ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port 16-bit external SRAM between the CPU's two memory ports.
  - Instruction fetch: B port.
  - Data access: A port, driven by the 2-bit memory control from the execute stage.
- Sequences the SRAM strobe timing through a small FSM.
- Drives a global stall, which the pipeline uses to hold while its requests are outstanding.
- Sits between the cpu top level and the board SRAM pins.

Parameters:
- ADDR_W, 16, width of the address on both CPU ports and the SRAM.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, extra cycles per SRAM access. Must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- if_req  in  1  instruction fetch requested this pipeline cycle
- if_addr  in  ADDR_W  fetch address (Baddr)
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  fetch served in the current pipeline cycle
- me_ctrl  in  2  data op: 00 none, 01 read, 10 write, 11 treated as none
- me_addr  in  ADDR_W  data address (Aaddr)
- me_wdata  in  DATA_W  store data
- me_rdata  out  DATA_W  loaded word, registered
- me_ready  out  1  data op served in the current pipeline cycle
- stall  out  1  pipeline hold, combinational
- ram_addr  out  ADDR_W  SRAM address
- ram_wdata  out  DATA_W  SRAM write data
- ram_rdata  in  DATA_W  SRAM read data
- ram_data_oe  out  1  drive SRAM data bus (pad tri-state enable)
- ram_ce_n  out  1  chip enable, active low
- ram_oe_n  out  1  output enable, active low
- ram_we_n  out  1  write enable, active low

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE, cnt=0, served flags=0, if_rdata=0, me_rdata=0.
  - ram_ce_n=ram_oe_n=ram_we_n=1, ram_data_oe=0, ram_addr=0, ram_wdata=0.
  - Reset in the middle of an access aborts it immediately; no strobe glitches low.
- Pending and stall:
  - me_pend = (me_ctrl∈{01,10}) & ~me_served.
  - if_pend = if_req & ~if_served.
  - stall = me_pend | if_pend.
  - me_ready = me_served; if_ready = if_served.
- Served flags:
  - Set at the edge ending the final cycle of the corresponding access.
  - Both cleared at any edge where stall=0, i.e. when the pipeline advances.
- States: IDLE, IF_RD, ME_RD, ME_WR. cnt runs 0..WAIT_CYCLES in each access state.
- IDLE arbitration:
  - me_pend → ME_RD or ME_WR (data has priority); else if_pend → IF_RD; else stay.
  - Address and data are captured into ram_addr and ram_wdata at the same edge.
- Access duration: every access state lasts exactly WAIT_CYCLES+1 cycles, then returns to IDLE. There is no back-to-back access without an IDLE cycle between.
- Reads (IF_RD, ME_RD):
  - ram_ce_n=0 and ram_oe_n=0 for the whole state.
  - At the edge leaving cnt=WAIT_CYCLES, ram_rdata is latched into if_rdata or me_rdata.
- Write (ME_WR):
  - ram_ce_n=0 and ram_data_oe=1 for the whole state.
  - ram_we_n=0 only for 1 ≤ cnt ≤ WAIT_CYCLES-1, giving address/data setup and hold of one cycle each.
  - ram_oe_n=1 throughout.
- Both requests in the same pipeline cycle: data access first, then fetch. stall falls only after both are served.
  - Total with default parameters: 3 + 1 + 3 + 1 = 8 cycles of stall.
- Inputs change while an access is in flight: ignored, because the address is registered. The pipeline is stalled, so inputs are stable anyway.
- Read data outputs hold their value until the next access of the same type completes.

Decomposition:
- Package ram_arb_pkg:
  - State encoding: IDLE=2'd0, IF_RD=2'd1, ME_RD=2'd2, ME_WR=2'd3.
  - MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10.
- Sub-module sram_strobe_gen:
  - Contains the cnt counter and the ce/oe/we/data_oe generation from (state, cnt).
  - Emits an access_last pulse.
- The top level holds arbitration, the served flags and the data registers.

Test Plan:
- Reset mid-write: assert rst=0 in ME_WR at cnt=1 → ram_we_n=1, ram_ce_n=1 and ram_data_oe=0 in the same cycle; stall=0 once rst=1 with no requests.
- Fetch only: if_req=1, if_addr=16'h0040, SRAM returns 16'h1234 → stall high for 4 cycles; ram_oe_n low for 3 cycles; if_rdata=16'h1234 and if_ready=1 when stall falls.
- Data write: me_ctrl=10, me_addr=16'h8000, me_wdata=16'hBEEF → ram_we_n low for exactly 1 cycle (the middle one); ram_data_oe high 3 cycles with ram_wdata=16'hBEEF; a model read of 16'h8000 returns 16'hBEEF.
- Simultaneous: if_req=1 and me_ctrl=01 → ME_RD precedes IF_RD; stall high 8 cycles; me_ready rises at cycle 4 while stall stays high; no second data access.
- Back-to-back pipeline cycles: 3 consecutive fetches at 16'h0000/1/2 → exactly 3 SRAM reads; stall low exactly one cycle between them; served flags clear each time.
- me_ctrl=11 with if_req=0 → stall=0, no SRAM strobes.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state encoding and memory-op codes for the SRAM port arbiter
package ram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        ME_RD = 2'd2,
        ME_WR = 2'd3
    } arbState_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    function automatic logic isMemOp(input logic [1:0] ctrl);
        return ctrl == MEM_READ || ctrl == MEM_WRITE;
    endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: CPU fetch/data ports plus SRAM pins of the arbiter
//   if_*   instruction fetch port (B port)
//   me_*   data access port (A port), me_ctrl 00 none / 01 read / 10 write / 11 none
//   stall  pipeline hold
//   ram_*  board SRAM pins, strobes active low
//   slave  = arbiter view, master = pipeline + SRAM view
interface ram_port_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic [1:0]        me_ctrl;
    logic [ADDR_W-1:0] me_addr;
    logic [DATA_W-1:0] me_wdata;
    logic [DATA_W-1:0] me_rdata;
    logic              me_ready;
    logic              stall;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_data_oe;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    modport slave (
        input  if_req, if_addr, me_ctrl, me_addr, me_wdata, ram_rdata,
        output if_rdata, if_ready, me_rdata, me_ready, stall,
               ram_addr, ram_wdata, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output if_req, if_addr, me_ctrl, me_addr, me_wdata, ram_rdata,
        input  if_rdata, if_ready, me_rdata, me_ready, stall,
               ram_addr, ram_wdata, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/sram_strobe_gen.sv
// sram_strobe_gen: per-access cycle counter and SRAM strobe decode from (state, cnt)
//   clk, rst    clock, async active-low reset
//   state       arbiter FSM state
//   accessLast  high in the final cycle of an access
//   ram*        ce_n / oe_n / we_n / data_oe pad controls
module sram_strobe_gen
    import ram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  arbState_t state,
    output logic      accessLast,
    output logic      ramCeN,
    output logic      ramOeN,
    output logic      ramWeN,
    output logic      ramDataOe
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= (state == IDLE || accessLast) ? '0 : cnt + 1'b1;

    // Strobes decode straight from registered state, so an async reset forces them inactive at once.
    // we_n is held off in the first and last write cycles to give one cycle of setup and hold.
    always_comb begin
        accessLast = state != IDLE && cnt == CNT_LAST;
        ramCeN     = state == IDLE;
        ramOeN     = !(state == IF_RD || state == ME_RD);
        ramWeN     = !(state == ME_WR && cnt != '0 && cnt != CNT_LAST);
        ramDataOe  = state == ME_WR;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port SRAM between the fetch and data ports, stalling the pipeline
//   clk, rst  clock, async active-low reset
//   bus       ram_port_arbiter_if.slave: fetch port, data port, stall and SRAM pins
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     bus
);
    arbState_t         state, nextState;
    logic              accessLast, meOp, mePend, ifPend, stall;
    logic              meServed, ifServed;
    logic [DATA_W-1:0] ifRdata, meRdata, ramWdata;
    logic [ADDR_W-1:0] ramAddr;
    logic              ramCeN, ramOeN, ramWeN, ramDataOe;

    sram_strobe_gen #(.WAIT_CYCLES(WAIT_CYCLES)) strobeGen (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .accessLast(accessLast),
        .ramCeN    (ramCeN),
        .ramOeN    (ramOeN),
        .ramWeN    (ramWeN),
        .ramDataOe (ramDataOe)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nextState;

    // Data port wins arbitration; every access drops back to IDLE before the next one.
    always_comb
        nextState = state == IDLE ? (mePend ? (bus.me_ctrl == MEM_READ ? ME_RD : ME_WR) :
                                     ifPend ? IF_RD : IDLE) :
                    accessLast    ? IDLE : state;

    always_comb begin
        meOp   = isMemOp(bus.me_ctrl);
        mePend = meOp & ~meServed;
        ifPend = bus.if_req & ~ifServed;
        stall  = mePend | ifPend;
    end

    // Served flags remember finished accesses until the pipeline advances (stall low).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meServed <= 1'b0;
            ifServed <= 1'b0;
            ifRdata  <= '0;
            meRdata  <= '0;
            ramAddr  <= '0;
            ramWdata <= '0;
        end else begin
            if (!stall) begin
                meServed <= 1'b0;
                ifServed <= 1'b0;
            end else if (accessLast) begin
                if (state == IF_RD) ifServed <= 1'b1;
                else                meServed <= 1'b1;
            end
            if (accessLast && state == IF_RD) ifRdata <= bus.ram_rdata;
            if (accessLast && state == ME_RD) meRdata <= bus.ram_rdata;
            if (state == IDLE && mePend) begin
                ramAddr  <= bus.me_addr;
                ramWdata <= bus.me_wdata;
            end else if (state == IDLE && ifPend) begin
                ramAddr  <= bus.if_addr;
            end
        end
    end

    assign bus.stall       = stall;
    assign bus.me_ready    = meServed;
    assign bus.if_ready    = ifServed;
    assign bus.me_rdata    = meRdata;
    assign bus.if_rdata    = ifRdata;
    assign bus.ram_addr    = ramAddr;
    assign bus.ram_wdata   = ramWdata;
    assign bus.ram_ce_n    = ramCeN;
    assign bus.ram_oe_n    = ramOeN;
    assign bus.ram_we_n    = ramWeN;
    assign bus.ram_data_oe = ramDataOe;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table, hand-written and random checks of ram_port_arbiter against a transaction-level model
module tb_ram_port_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [15:0] bg(input int a);
        return 16'((a * 16'h9E37) ^ 16'h5A5A);
    endfunction

    // Board SRAM model: asynchronous read, write while ce_n and we_n are low at a rising edge.
    logic [15:0] mem [0:65535];
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk)
        if (!bus.ram_ce_n && !bus.ram_we_n) mem[bus.ram_addr] = bus.ram_wdata;

    // Reference: memory contents as the pipeline expects them after each completed transaction.
    logic [15:0] refMem [int];
    logic [15:0] expMe, expIf;

    function automatic logic [15:0] refRd(input logic [15:0] a);
        return refMem.exists(int'(a)) ? refMem[int'(a)] : bg(int'(a));
    endfunction

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string n, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // One pipeline cycle: present requests, follow the stall, then check against the model.
    task automatic runOp(input logic [1:0] c, input logic [15:0] ma, input logic [15:0] wd,
                         input logic ir, input logic [15:0] ia, input int expStall);
        int stallCyc, acc, oeLow, weLow, doe, meRdyAt, k;
        logic prevCe, done, isMe, isRd, isWr, wrOk;
        bus.me_ctrl  = c;
        bus.me_addr  = ma;
        bus.me_wdata = wd;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        stallCyc = 0; acc = 0; oeLow = 0; weLow = 0; doe = 0; meRdyAt = -1;
        prevCe = 1'b1; done = 1'b0; wrOk = 1'b1; k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (!bus.ram_ce_n && prevCe) acc++;
            prevCe = bus.ram_ce_n;
            if (!bus.ram_oe_n) oeLow++;
            if (bus.ram_data_oe) doe++;
            if (!bus.ram_we_n) begin
                weLow++;
                if (bus.ram_wdata != wd || bus.ram_addr != ma || !bus.ram_data_oe) wrOk = 1'b0;
            end
            if (bus.me_ready && meRdyAt < 0) meRdyAt = k;
            if (!bus.stall) done = 1'b1;
            else            stallCyc++;
            k++;
        end
        chk("stall_bounded", longint'(done), 1);
        isMe = c == 2'b01 || c == 2'b10;
        isRd = c == 2'b01;
        isWr = c == 2'b10;
        if (isWr) refMem[int'(ma)] = wd;
        if (isRd) expMe = refRd(ma);
        if (ir)   expIf = refRd(ia);
        chk("stall_cycles", stallCyc, expStall);
        chk("me_ready", longint'(bus.me_ready), longint'(isMe));
        chk("if_ready", longint'(bus.if_ready), longint'(ir));
        chk("me_ready_cycle", meRdyAt, isMe ? W + 2 : -1);
        chk("me_rdata", bus.me_rdata, expMe);
        chk("if_rdata", bus.if_rdata, expIf);
        chk("sram_accesses", acc, int'(isMe) + int'(ir));
        chk("oe_low_cycles", oeLow, (int'(isRd) + int'(ir)) * (W + 1));
        chk("we_low_cycles", weLow, isWr ? W - 1 : 0);
        chk("data_oe_cycles", doe, isWr ? W + 1 : 0);
        chk("write_addr_data", longint'(wrOk), 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  ctrl;
        logic [15:0] maddr;
        logic [15:0] wdata;
        logic        ifr;
        logic [15:0] iaddr;
        int          expStall;
    } vec_t;

    vec_t tbl [8];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = bg(i);
        mem[16'h0040] = 16'h1234;
        refMem[16'h0040] = 16'h1234;
        expMe = '0;
        expIf = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.me_ctrl = 2'b00; bus.me_addr = '0; bus.me_wdata = '0;

        tbl[0] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0040, 4};
        tbl[1] = '{2'b10, 16'h8000, 16'hBEEF, 1'b0, 16'h0000, 4};
        tbl[2] = '{2'b01, 16'h8000, 16'h0000, 1'b0, 16'h0000, 4};
        tbl[3] = '{2'b01, 16'h8000, 16'h0000, 1'b1, 16'h0040, 8};
        tbl[4] = '{2'b11, 16'h1111, 16'h2222, 1'b0, 16'h0000, 0};
        tbl[5] = '{2'b11, 16'h1111, 16'h2222, 1'b1, 16'h0041, 4};
        tbl[6] = '{2'b10, 16'h0050, 16'hCAFE, 1'b1, 16'h0050, 8};
        tbl[7] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0};

        #2;
        chk("rst_ce_n", longint'(bus.ram_ce_n), 1);
        chk("rst_oe_n", longint'(bus.ram_oe_n), 1);
        chk("rst_we_n", longint'(bus.ram_we_n), 1);
        chk("rst_data_oe", longint'(bus.ram_data_oe), 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_rdata", {bus.if_rdata, bus.me_rdata}, 0);
        chk("rst_stall", longint'(bus.stall), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            runOp(tbl[i].ctrl, tbl[i].maddr, tbl[i].wdata, tbl[i].ifr, tbl[i].iaddr, tbl[i].expStall);
            if (i == 0) chk("fetch_0040", bus.if_rdata, 16'h1234);
            if (i == 2) chk("readback_8000", bus.me_rdata, 16'hBEEF);
        end

        for (int a = 0; a < 3; a++) runOp(2'b00, 16'h0, 16'h0, 1'b1, 16'(a), 4);

        // Reset asserted in the middle of a write, one cycle into the we_n window.
        bus.me_ctrl = 2'b10; bus.me_addr = 16'h0123; bus.me_wdata = 16'hAAAA; bus.if_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midwr_we_low", longint'(bus.ram_we_n), 0);
        rst = 1'b0;
        #1;
        chk("midwr_we_n", longint'(bus.ram_we_n), 1);
        chk("midwr_ce_n", longint'(bus.ram_ce_n), 1);
        chk("midwr_data_oe", longint'(bus.ram_data_oe), 0);
        bus.me_ctrl = 2'b00;
        #1;
        chk("midwr_stall", longint'(bus.stall), 0);
        chk("midwr_rdata", {bus.if_rdata, bus.me_rdata}, 0);
        expMe = '0;
        expIf = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_stall", longint'(bus.stall), 0);
        chk("post_rst_ce_n", longint'(bus.ram_ce_n), 1);
        runOp(2'b01, 16'h0123, 16'h0, 1'b0, 16'h0, 4);

        for (int r = 0; r < 40; r++) begin
            logic [1:0] c;
            logic ir;
            int es;
            c  = 2'($urandom_range(0, 3));
            ir = 1'($urandom_range(0, 1));
            es = ((c == 2'b01 || c == 2'b10) ? W + 2 : 0) + (ir ? W + 2 : 0);
            runOp(c, 16'h0120 + 16'($urandom_range(0, 7)), 16'($urandom),
                  ir, 16'h0120 + 16'($urandom_range(0, 7)), es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
